motor_speed_driver: RTL and testbench

//  Consumes the signed per-wheel speed commands produced by the balance control loop.

---
 rtl/motor_speed_driver_pkg.sv | 40 ++++
 rtl/motor_speed_driver_if.sv | 27 ++
 rtl/motor_speed_driver_channel.sv | 123 ++++++++++++
 rtl/motor_speed_driver.sv | 85 ++++++++
 tb/tb_motor_speed_driver.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_speed_driver_pkg.sv
// Shared types, widths and ramp helpers for the motor speed driver.
package motor_pkg;

    localparam int unsigned PWM_BITS   = 9;
    localparam int unsigned SPEED_BITS = 10;
    localparam int          SPEED_MAX  = 511;

    typedef logic signed [SPEED_BITS-1:0] speed_t;
    typedef logic signed [SPEED_BITS:0]   speed_ext_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEADTIME
    } chan_state_e;

    // Widen a command to the arithmetic width, folding -512 onto -511.
    function automatic speed_ext_t clamp_speed(input speed_t t);
        if (t == speed_t'(-SPEED_MAX - 1)) begin
            return speed_ext_t'(-SPEED_MAX);
        end
        return speed_ext_t'(t);
    endfunction

    // Move cur toward tgt by at most step, landing exactly on tgt when close.
    function automatic speed_ext_t step_toward(input speed_ext_t cur,
                                               input speed_ext_t tgt,
                                               input speed_ext_t step);
        speed_ext_t diff;
        diff = tgt - cur;
        if (diff > step) begin
            return cur + step;
        end
        if (diff < -step) begin
            return cur - step;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/motor_speed_driver_if.sv
// Command and bridge-pin bundle between the control loop and the driver.
interface motor_speed_driver_if;

    logic              enable;
    motor_pkg::speed_t target_speed_left;
    motor_pkg::speed_t target_speed_right;
    logic              pwm_left;
    logic              dir_left;
    logic              pwm_right;
    logic              dir_right;
    motor_pkg::speed_t applied_speed_left;
    motor_pkg::speed_t applied_speed_right;
    logic              period_start;

    modport master (
        output enable, target_speed_left, target_speed_right,
        input  pwm_left, dir_left, pwm_right, dir_right,
        input  applied_speed_left, applied_speed_right, period_start
    );

    modport slave (
        input  enable, target_speed_left, target_speed_right,
        output pwm_left, dir_left, pwm_right, dir_right,
        output applied_speed_left, applied_speed_right, period_start
    );

endinterface

// File: rtl/motor_speed_driver_channel.sv
// One H-bridge channel: slew-limited ramp, reversal dead time, direction and PWM register.
module motor_channel
    import motor_pkg::*;
#(
    parameter int unsigned RAMP_STEP        = 8,
    parameter int unsigned DEADTIME_PERIODS = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                i_enable,
    input  speed_t              i_target,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_boundary,
    output logic                o_pwm,
    output logic                o_dir,
    output speed_t              o_applied
);

    localparam int unsigned DT_W = $clog2(DEADTIME_PERIODS + 1);
    localparam speed_ext_t  STEP = speed_ext_t'(RAMP_STEP);

    chan_state_e           r_state;
    chan_state_e           w_next_state;
    logic                  r_dir;
    logic                  w_next_dir;
    speed_t                r_applied;
    speed_ext_t            w_next_applied;
    logic [DT_W-1:0]       r_dt_cnt;
    logic [DT_W-1:0]       w_next_dt;
    logic                  r_pwm;
    logic                  w_next_pwm;

    speed_ext_t            w_tgt;
    speed_ext_t            w_app;
    logic                  w_tgt_neg;
    logic                  w_tgt_zero;
    logic                  w_opposite;
    logic [SPEED_BITS-1:0] w_mag;

    assign w_tgt      = clamp_speed(i_target);
    assign w_app      = speed_ext_t'(r_applied);
    assign w_tgt_neg  = w_tgt[SPEED_BITS];
    assign w_tgt_zero = (w_tgt == '0);
    // Applied is always zero or of the sign recorded in dir, so dir stands in for its sign.
    assign w_opposite = !w_tgt_zero && (w_tgt_neg != r_dir);
    assign w_mag      = r_applied[SPEED_BITS-1] ? SPEED_BITS'(-r_applied) : SPEED_BITS'(r_applied);

    // State register and channel datapath registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_dir     <= 1'b0;
            r_applied <= '0;
            r_dt_cnt  <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_dir     <= w_next_dir;
            r_applied <= SPEED_BITS'(w_next_applied);
            r_dt_cnt  <= w_next_dt;
            r_pwm     <= w_next_pwm;
        end
    end

    // Next-state, ramp and duty compare; disable overrides any boundary update.
    always_comb begin
        w_next_state   = r_state;
        w_next_dir     = r_dir;
        w_next_applied = w_app;
        w_next_dt      = r_dt_cnt;
        w_next_pwm     = (r_state == RUN) && ({1'b0, i_pwm_cnt} < w_mag);

        if (!i_enable) begin
            w_next_state   = IDLE;
            w_next_applied = '0;
            w_next_pwm     = 1'b0;
        end else if (i_boundary) begin
            case (r_state)
                IDLE: begin
                    w_next_dir     = w_tgt_neg;
                    w_next_applied = step_toward('0, w_tgt, STEP);
                    w_next_state   = RUN;
                end
                RUN: begin
                    if (w_opposite) begin
                        if (w_app != '0) begin
                            w_next_applied = step_toward(w_app, '0, STEP);
                        end else begin
                            w_next_state = DEADTIME;
                            w_next_dt    = DT_W'(DEADTIME_PERIODS);
                        end
                    end else begin
                        w_next_applied = step_toward(w_app, w_tgt, STEP);
                    end
                end
                DEADTIME: begin
                    if (r_dt_cnt <= DT_W'(1)) begin
                        w_next_dt    = '0;
                        w_next_dir   = ~r_dir;
                        w_next_state = RUN;
                        // A target that flipped back during the dead time waits at zero.
                        if (w_tgt_zero || (w_tgt_neg == ~r_dir)) begin
                            w_next_applied = step_toward('0, w_tgt, STEP);
                        end else begin
                            w_next_applied = '0;
                        end
                    end else begin
                        w_next_dt = r_dt_cnt - 1'b1;
                    end
                end
                default: begin
                    w_next_state   = IDLE;
                    w_next_applied = '0;
                end
            endcase
        end
    end

    assign o_pwm     = r_pwm;
    assign o_dir     = r_dir;
    assign o_applied = r_applied;

endmodule

// File: rtl/motor_speed_driver.sv
// Shared PWM timebase plus two independent motor channels.
module motor_speed_driver
    import motor_pkg::*;
#(
    parameter int unsigned PRESCALE         = 98,
    parameter int unsigned RAMP_STEP        = 8,
    parameter int unsigned DEADTIME_PERIODS = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    motor_speed_driver_if.slave  bus
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]     r_prescale;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_period_start;
    logic                w_tick;
    logic                w_boundary;

    logic                w_pwm_left;
    logic                w_dir_left;
    speed_t              w_applied_left;
    logic                w_pwm_right;
    logic                w_dir_right;
    speed_t              w_applied_right;

    assign w_tick     = (r_prescale == PS_W'(PRESCALE - 1));
    assign w_boundary = w_tick && (r_pwm_cnt == '1);

    // Prescaler, PWM counter and period-start pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_prescale     <= '0;
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_prescale     <= w_tick ? '0 : r_prescale + 1'b1;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
            r_period_start <= w_boundary;
        end
    end

    motor_channel #(
        .RAMP_STEP        (RAMP_STEP),
        .DEADTIME_PERIODS (DEADTIME_PERIODS)
    ) u_left (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_enable   (bus.enable),
        .i_target   (bus.target_speed_left),
        .i_pwm_cnt  (r_pwm_cnt),
        .i_boundary (w_boundary),
        .o_pwm      (w_pwm_left),
        .o_dir      (w_dir_left),
        .o_applied  (w_applied_left)
    );

    motor_channel #(
        .RAMP_STEP        (RAMP_STEP),
        .DEADTIME_PERIODS (DEADTIME_PERIODS)
    ) u_right (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_enable   (bus.enable),
        .i_target   (bus.target_speed_right),
        .i_pwm_cnt  (r_pwm_cnt),
        .i_boundary (w_boundary),
        .o_pwm      (w_pwm_right),
        .o_dir      (w_dir_right),
        .o_applied  (w_applied_right)
    );

    assign bus.pwm_left            = w_pwm_left;
    assign bus.dir_left            = w_dir_left;
    assign bus.applied_speed_left  = w_applied_left;
    assign bus.pwm_right           = w_pwm_right;
    assign bus.dir_right           = w_dir_right;
    assign bus.applied_speed_right = w_applied_right;
    assign bus.period_start        = r_period_start;

endmodule

// File: tb/tb_motor_speed_driver.sv
// Bench for motor_speed_driver: directed scenarios plus random commands against an integer model.
module tb_motor_speed_driver;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    motor_speed_driver_if ifc ();

    motor_speed_driver #(
        .PRESCALE         (1),
        .RAMP_STEP        (8),
        .DEADTIME_PERIODS (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference model (integers, one period = 512 cycles) ----------------
    int m_cnt = 0;
    int m_ps = 0;
    int m_st[2];    // 0 idle, 1 run, 2 dead time
    int m_app[2];
    int m_dir[2];
    int m_dt[2];
    int m_pwm[2];
    bit m_started = 1'b0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int mstep(input int cur, input int tgt);
        if (tgt - cur > 8) return cur + 8;
        if (tgt - cur < -8) return cur - 8;
        return tgt;
    endfunction

    task automatic model_channel(input int c, input int raw);
        int t;
        int ref_neg;
        t = (raw == -512) ? -511 : raw;
        if (m_st[c] == 0) begin
            m_dir[c] = (t < 0) ? 1 : 0;
            m_app[c] = mstep(0, t);
            m_st[c]  = 1;
        end else if (m_st[c] == 1) begin
            ref_neg = (m_app[c] != 0) ? ((m_app[c] < 0) ? 1 : 0) : m_dir[c];
            if (t != 0 && ((t < 0) ? 1 : 0) != ref_neg) begin
                if (m_app[c] != 0) m_app[c] = mstep(m_app[c], 0);
                else begin
                    m_st[c] = 2;
                    m_dt[c] = 2;
                end
            end else begin
                m_app[c] = mstep(m_app[c], t);
            end
        end else begin
            m_dt[c] = m_dt[c] - 1;
            if (m_dt[c] == 0) begin
                m_dir[c] = 1 - m_dir[c];
                m_st[c]  = 1;
                if (t == 0 || ((t < 0) ? 1 : 0) == m_dir[c]) m_app[c] = mstep(0, t);
                else m_app[c] = 0;
            end
        end
    endtask

    always @(posedge clock) begin
        int tg[2];
        bit bnd;
        tg[0] = int'(ifc.target_speed_left);
        tg[1] = int'(ifc.target_speed_right);
        if (!reset_n) begin
            m_cnt = 0;
            m_ps  = 0;
            for (int c = 0; c < 2; c++) begin
                m_st[c] = 0; m_app[c] = 0; m_dir[c] = 0; m_dt[c] = 0; m_pwm[c] = 0;
            end
            m_started = 1'b1;
        end else begin
            bnd = (m_cnt == 511);
            for (int c = 0; c < 2; c++) begin
                m_pwm[c] = (m_st[c] == 1 && m_cnt < iabs(m_app[c])) ? 1 : 0;
                if (!ifc.enable) begin
                    m_st[c] = 0; m_app[c] = 0; m_pwm[c] = 0;
                end else if (bnd) begin
                    model_channel(c, tg[c]);
                end
            end
            m_ps  = bnd ? 1 : 0;
            m_cnt = (m_cnt + 1) % 512;
        end
    end

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (m_started) begin
            chk("pwm_left",     ifc.pwm_left,            m_pwm[0]);
            chk("dir_left",     ifc.dir_left,            m_dir[0]);
            chk("applied_left", ifc.applied_speed_left,  m_app[0]);
            chk("pwm_right",    ifc.pwm_right,           m_pwm[1]);
            chk("dir_right",    ifc.dir_right,           m_dir[1]);
            chk("applied_right", ifc.applied_speed_right, m_app[1]);
            chk("period_start", ifc.period_start,        m_ps);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic next_period();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (ifc.period_start !== 1'b1 && n < 700);
        if (n >= 700) begin
            checks++;
            errors++;
            $display("FAIL period_timeout: got no period_start in %0d cycles expected one", n);
        end
    endtask

    // Called on a period_start negedge; counts pwm-high cycles over the period.
    task automatic count_period(output int hl, output int hr);
        hl = 0;
        hr = 0;
        for (int i = 0; i < 512; i++) begin
            if (i != 0) @(negedge clock);
            hl += int'(ifc.pwm_left);
            hr += int'(ifc.pwm_right);
        end
    endtask

    function automatic logic signed [9:0] rnd_target();
        logic [9:0] v;
        if ($urandom_range(0, 7) == 0) return '0;
        v = 10'($urandom_range(0, 1023));
        return $signed(v);
    endfunction

    initial begin
        int hl, hr, idle_hi;
        int ea[6];
        int ed[6];
        ea = '{8, 0, 0, 0, -8, -16};
        ed = '{0, 0, 0, 0, 1, 1};

        // Reset with live commands.
        reset_n = 1'b0;
        ifc.enable = 1'b1;
        ifc.target_speed_left  = 10'sd300;
        ifc.target_speed_right = -10'sd300;
        repeat (3) @(negedge clock);
        chk("rst_pwm_left", ifc.pwm_left, 0);
        chk("rst_dir_right", ifc.dir_right, 0);
        chk("rst_applied_left", ifc.applied_speed_left, 0);
        chk("rst_applied_right", ifc.applied_speed_right, 0);
        chk("rst_period_start", ifc.period_start, 0);
        reset_n = 1'b1;
        ifc.enable = 1'b0;
        idle_hi = 0;
        for (int i = 0; i < 3 * 512; i++) begin
            @(negedge clock);
            idle_hi += int'(ifc.pwm_left) + int'(ifc.pwm_right);
        end
        chk("disabled_pwm_high_cycles", idle_hi, 0);

        // Ramp left to +100; right heads for the clamped -512 in parallel.
        ifc.enable = 1'b1;
        ifc.target_speed_left  = 10'sd100;
        ifc.target_speed_right = -10'sd512;
        next_period();
        chk("ramp_first_step", ifc.applied_speed_left, 8);
        repeat (11) next_period();
        chk("ramp_step12", ifc.applied_speed_left, 96);
        next_period();
        chk("ramp_final", ifc.applied_speed_left, 100);
        chk("ramp_dir", ifc.dir_left, 0);
        count_period(hl, hr);
        chk("duty_100_cycles", hl, 100);

        // Reversal through dead time.
        ifc.target_speed_left = 10'sd16;
        for (int i = 0; i < 20; i++) begin
            next_period();
            if (ifc.applied_speed_left == 10'sd16) break;
        end
        chk("rev_start", ifc.applied_speed_left, 16);
        ifc.target_speed_left = -10'sd16;
        for (int k = 0; k < 6; k++) begin
            next_period();
            chk("rev_applied", ifc.applied_speed_left, ea[k]);
            chk("rev_dir", ifc.dir_left, ed[k]);
        end

        // Clamp, full duty, and a mid-period command change.
        for (int i = 0; i < 80; i++) begin
            if (ifc.applied_speed_right == -10'sd511) break;
            next_period();
        end
        chk("clamp_applied", ifc.applied_speed_right, -511);
        chk("clamp_dir", ifc.dir_right, 1);
        next_period();
        count_period(hl, hr);
        chk("duty_511_cycles", hr, 511);
        next_period();
        hr = 0;
        for (int i = 0; i < 512; i++) begin
            if (i != 0) @(negedge clock);
            hr += int'(ifc.pwm_right);
            if (i == 200) ifc.target_speed_right = 10'sd50;
        end
        chk("midperiod_duty", hr, 511);
        next_period();
        chk("midperiod_next_applied", ifc.applied_speed_right, -503);

        // Disable mid-ramp.
        ifc.target_speed_left = -10'sd300;
        next_period();
        next_period();
        chk("abort_ramp_applied", ifc.applied_speed_left, -32);
        repeat (5) @(negedge clock);
        chk("abort_pre_pwm", ifc.pwm_left, 1);
        ifc.enable = 1'b0;
        @(negedge clock);
        chk("abort_pwm", ifc.pwm_left, 0);
        chk("abort_applied", ifc.applied_speed_left, 0);
        chk("abort_dir_held", ifc.dir_left, 1);
        repeat (3) @(negedge clock);

        // Reset in the middle of a dead time.
        ifc.enable = 1'b1;
        ifc.target_speed_left  = -10'sd8;
        ifc.target_speed_right = 10'sd0;
        next_period();
        chk("restart_dir", ifc.dir_left, 1);
        chk("restart_applied", ifc.applied_speed_left, -8);
        ifc.target_speed_left = 10'sd40;
        next_period();
        next_period();
        repeat (100) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("dtreset_dir", ifc.dir_left, 0);
        chk("dtreset_period_start", ifc.period_start, 0);
        chk("dtreset_applied", ifc.applied_speed_left, 0);
        reset_n = 1'b1;

        // Random commands and occasional disables.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 299) == 0) ifc.target_speed_left  = rnd_target();
            if ($urandom_range(0, 299) == 0) ifc.target_speed_right = rnd_target();
            if (ifc.enable && $urandom_range(0, 5999) == 0) ifc.enable = 1'b0;
            else if (!ifc.enable && $urandom_range(0, 199) == 0) ifc.enable = 1'b1;
        end

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
